// File: rtl/bus_ram_responder_if.sv
// ---------------------------------------------------------------------------
// bus_ram_responder_if
//   Bus signal bundle between a CPU-side bus initiator and the RAM target.
//
//   bus_addr        initiator -> target  byte address
//   bus_read        initiator -> target  read request
//   bus_write       initiator -> target  write request
//   bus_writedata   initiator -> target  write data
//   bus_byteenable  initiator -> target  write byte lanes (ignored on reads)
//   bus_readdata    target -> initiator  read data, valid while waitrequest=0
//   bus_response    target -> initiator  00 OKAY, 10 SLVERR, 11 DECODEERROR
//   bus_waitrequest target -> initiator  0 = transaction completes this cycle
// ---------------------------------------------------------------------------
interface bus_ram_responder_if;
   logic [31:0] bus_addr;
   logic        bus_read;
   logic        bus_write;
   logic [31:0] bus_writedata;
   logic [3:0]  bus_byteenable;
   logic [31:0] bus_readdata;
   logic [1:0]  bus_response;
   logic        bus_waitrequest;

   modport master (
      output bus_addr, bus_read, bus_write, bus_writedata, bus_byteenable,
      input  bus_readdata, bus_response, bus_waitrequest
   );

   modport slave (
      input  bus_addr, bus_read, bus_write, bus_writedata, bus_byteenable,
      output bus_readdata, bus_response, bus_waitrequest
   );
endinterface

// File: rtl/bus_ram_responder.sv
// ---------------------------------------------------------------------------
// bus_ram_responder
//   Memory-mapped RAM target (program/data RAM for the DSI controller's soft
//   core). bus_waitrequest stays high except for a single ready cycle per
//   transaction, during which bus_readdata/bus_response are valid; they hold
//   until the next ready cycle. Out-of-window accesses answer DECODEERROR,
//   misaligned or simultaneous read+write accesses answer SLVERR; errored
//   accesses never touch the RAM.
//
//   Parameters
//     BASE_ADDR    byte address of word 0, aligned to 4*MEM_WORDS
//     MEM_WORDS    depth in 32-bit words, power of two, >= 2
//     WAIT_STATES  extra cycles between accept and response, 0..15
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset (RAM contents are not reset)
//     bus    bus_ram_responder_if slave modport
// ---------------------------------------------------------------------------
module bus_ram_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   bus_ram_responder_if.slave bus
);

   localparam int unsigned AW     = $clog2(MEM_WORDS);
   localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * MEM_WORDS);
   localparam logic [3:0]  WS4    = 4'(WAIT_STATES);

   generate
      if (WAIT_STATES > 15) begin : g_bad_wait_states
         $error("bus_ram_responder: WAIT_STATES must be in 0..15");
      end
      if ((MEM_WORDS < 2) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_bad_mem_words
         $error("bus_ram_responder: MEM_WORDS must be a power of two >= 2");
      end
      if ((BASE_ADDR & 32'(4 * MEM_WORDS - 1)) != 32'd0) begin : g_bad_base
         $error("bus_ram_responder: BASE_ADDR must be aligned to 4*MEM_WORDS");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        capture;
   logic        enter_resp;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        rd_q;
   logic        wr_q;

   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_be;
   logic        sel_rd;
   logic        sel_wr;

   logic        in_range;
   logic [AW-1:0] idx;
   resp_e       code;

   logic [31:0] readdata_q;
   resp_e       response_q;

   logic [31:0] mem [MEM_WORDS];

   // With WAIT_STATES=0 the response is registered on the accept edge itself,
   // before the capture registers hold the request, so decode from the live
   // bus while idle and from the captured copy otherwise.
   always_comb begin
      if (state_q == S_IDLE) begin
         sel_addr  = bus.bus_addr;
         sel_wdata = bus.bus_writedata;
         sel_be    = bus.bus_byteenable;
         sel_rd    = bus.bus_read;
         sel_wr    = bus.bus_write;
      end else begin
         sel_addr  = addr_q;
         sel_wdata = wdata_q;
         sel_be    = be_q;
         sel_rd    = rd_q;
         sel_wr    = wr_q;
      end
   end

   // Address decode and error priority: window, then alignment, then rd+wr.
   always_comb begin
      in_range = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);
      idx      = sel_addr[AW+1:2];
      code     = RESP_OKAY;
      if (!in_range) begin
         code = RESP_DECERR;
      end else if (sel_addr[1:0] != 2'b00) begin
         code = RESP_SLVERR;
      end else if (sel_rd && sel_wr) begin
         code = RESP_SLVERR;
      end
   end

   // Next-state logic. The counter is loaded with WAIT_STATES on accept and
   // each WAIT cycle consumes one count; the last one moves on to RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.bus_read || bus.bus_write) begin
               capture = 1'b1;
               cnt_d   = WS4;
               state_d = (WS4 != 4'd0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         readdata_q <= '0;
         response_q <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            addr_q  <= bus.bus_addr;
            wdata_q <= bus.bus_writedata;
            be_q    <= bus.bus_byteenable;
            rd_q    <= bus.bus_read;
            wr_q    <= bus.bus_write;
         end
         if (enter_resp) begin
            response_q <= code;
            readdata_q <= ((code == RESP_OKAY) && sel_rd) ? mem[idx] : '0;
         end
      end
   end

   // RAM byte-lane writes commit on the edge entering RESP. The rst_n term
   // keeps a request seen while reset is held from committing through the
   // zero-wait-state path.
   always_ff @(posedge clk) begin
      if (rst_n && enter_resp && (code == RESP_OKAY) && sel_wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (sel_be[b]) begin
               mem[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.bus_readdata    = readdata_q;
   assign bus.bus_response    = response_q;
   assign bus.bus_waitrequest = (state_q != S_RESP);

endmodule

// File: tb/tb_bus_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_ram_responder
//   Three responders (WAIT_STATES 0, 1, 3) each run the same transaction plan
//   independently and back-to-back against a per-instance reference memory.
// ---------------------------------------------------------------------------
module tb_bus_ram_responder;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int unsigned WORDS = 1024;
   localparam int          NDUT  = 3;
   localparam int unsigned WS_OF [NDUT] = '{0, 1, 3};

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        rd;
      logic        wr;
      logic        drop;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bus_ram_responder_if if0 ();
   bus_ram_responder_if if1 ();
   bus_ram_responder_if if2 ();

   logic [31:0] addr_d  [NDUT];
   logic [31:0] wdata_d [NDUT];
   logic [3:0]  be_d    [NDUT];
   logic        rd_d    [NDUT];
   logic        wr_d    [NDUT];
   logic        wait_o  [NDUT];
   logic [31:0] rdata_o [NDUT];
   logic [1:0]  resp_o  [NDUT];

   assign if0.bus_addr = addr_d[0];  assign if0.bus_writedata = wdata_d[0];
   assign if0.bus_byteenable = be_d[0];
   assign if0.bus_read = rd_d[0];    assign if0.bus_write = wr_d[0];
   assign if1.bus_addr = addr_d[1];  assign if1.bus_writedata = wdata_d[1];
   assign if1.bus_byteenable = be_d[1];
   assign if1.bus_read = rd_d[1];    assign if1.bus_write = wr_d[1];
   assign if2.bus_addr = addr_d[2];  assign if2.bus_writedata = wdata_d[2];
   assign if2.bus_byteenable = be_d[2];
   assign if2.bus_read = rd_d[2];    assign if2.bus_write = wr_d[2];

   assign wait_o[0] = if0.bus_waitrequest; assign rdata_o[0] = if0.bus_readdata;
   assign resp_o[0] = if0.bus_response;
   assign wait_o[1] = if1.bus_waitrequest; assign rdata_o[1] = if1.bus_readdata;
   assign resp_o[1] = if1.bus_response;
   assign wait_o[2] = if2.bus_waitrequest; assign rdata_o[2] = if2.bus_readdata;
   assign resp_o[2] = if2.bus_response;

   bus_ram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(0))
      u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   bus_ram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(1))
      u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   bus_ram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(3))
      u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mdl [NDUT][WORDS];
   logic [31:0] last_rd   [NDUT];
   logic [1:0]  last_resp [NDUT];
   txn_t        plan [$];
   int          ptr  [NDUT];
   txn_t        cur  [NDUT];
   logic        busy [NDUT];
   int          cyc  [NDUT];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void add(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                               input logic rd, input logic wr, input logic drop);
      txn_t t;
      t.addr = a; t.wdata = d; t.be = be; t.rd = rd; t.wr = wr; t.drop = drop;
      plan.push_back(t);
   endfunction

   function automatic logic [1:0] exp_code(input txn_t t);
      if (t.addr < BASE || t.addr >= BASE + 32'(4 * WORDS)) return 2'b11;
      if (t.addr % 4 != 0) return 2'b10;
      if (t.rd && t.wr) return 2'b10;
      return 2'b00;
   endfunction

   task automatic complete(input int k);
      logic [1:0]  code;
      logic [31:0] exp_rd;
      int unsigned w;
      code   = exp_code(cur[k]);
      w      = (code == 2'b00) ? (cur[k].addr - BASE) / 4 : 0;
      exp_rd = (code == 2'b00 && cur[k].rd) ? mdl[k][w] : 32'h0;
      check_eq($sformatf("dut%0d latency @%h", k, cur[k].addr), 32'(cyc[k]), WS_OF[k] + 1);
      check_eq($sformatf("dut%0d response @%h", k, cur[k].addr), 32'(resp_o[k]), 32'(code));
      check_eq($sformatf("dut%0d readdata @%h", k, cur[k].addr), rdata_o[k], exp_rd);
      if (code == 2'b00 && cur[k].wr) begin
         for (int b = 0; b < 4; b++) begin
            if (cur[k].be[b]) mdl[k][w][8*b +: 8] = cur[k].wdata[8*b +: 8];
         end
      end
      last_rd[k]   = exp_rd;
      last_resp[k] = code;
   endtask

   task automatic service(input int k);
      if (busy[k]) begin
         cyc[k]++;
         if (cur[k].drop && cyc[k] == 1 && wait_o[k]) begin
            rd_d[k] = 1'b0; wr_d[k] = 1'b0;
            addr_d[k] = ~cur[k].addr; wdata_d[k] = ~cur[k].wdata; be_d[k] = ~cur[k].be;
         end
         if (!wait_o[k]) begin
            complete(k);
            rd_d[k] = 1'b0; wr_d[k] = 1'b0; busy[k] = 1'b0;
         end else if (cyc[k] > 20) begin
            check_eq($sformatf("dut%0d response timeout", k), 32'(cyc[k]), WS_OF[k] + 1);
            rd_d[k] = 1'b0; wr_d[k] = 1'b0; busy[k] = 1'b0;
         end
      end else begin
         check_eq($sformatf("dut%0d idle waitrequest", k), 32'(wait_o[k]), 32'd1);
         check_eq($sformatf("dut%0d held readdata", k), rdata_o[k], last_rd[k]);
         check_eq($sformatf("dut%0d held response", k), 32'(resp_o[k]), 32'(last_resp[k]));
         if (ptr[k] < plan.size()) begin
            cur[k] = plan[ptr[k]];
            ptr[k]++;
            addr_d[k] = cur[k].addr; wdata_d[k] = cur[k].wdata; be_d[k] = cur[k].be;
            rd_d[k] = cur[k].rd; wr_d[k] = cur[k].wr;
            busy[k] = 1'b1; cyc[k] = 0;
         end
      end
   endtask

   function automatic logic all_done();
      for (int k = 0; k < NDUT; k++) begin
         if (busy[k] || ptr[k] < plan.size()) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic run_plan();
      int guard;
      guard = 0;
      for (int k = 0; k < NDUT; k++) begin ptr[k] = 0; busy[k] = 1'b0; end
      while (!all_done()) begin
         @(negedge clk);
         guard++;
         if (guard > 30000) begin
            check_eq("plan cycle budget", 32'(guard), 32'd30000);
            return;
         end
         for (int k = 0; k < NDUT; k++) service(k);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         addr_d[k] = '0; wdata_d[k] = '0; be_d[k] = '0; rd_d[k] = 1'b0; wr_d[k] = 1'b0;
         last_rd[k] = '0; last_resp[k] = 2'b00; busy[k] = 1'b0; ptr[k] = 0; cyc[k] = 0;
         for (int w = 0; w < int'(WORDS); w++) mdl[k][w] = '0;
      end

      // RAM contents are undefined after power-up: zero the words the plan uses.
      for (int w = 0; w < 32; w++) add(BASE + 32'(4 * w), 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      for (int w = 1020; w < 1024; w++) add(BASE + 32'(4 * w), 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      add(32'h0001_0010, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1, 1'b0);
      add(32'h0001_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      add(32'h0001_0020, 32'h1122_3344, 4'hF, 1'b0, 1'b1, 1'b0);
      add(32'h0001_0020, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b1, 1'b0);
      add(32'h0001_0020, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
      add(32'h0002_0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
      add(32'h0001_0003, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 1'b0);
      add(32'h0001_0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
      for (int w = 0; w < 4; w++) add(BASE + 32'(4 * w), 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      add(32'h0001_0000, 32'h7777_7777, 4'hF, 1'b1, 1'b1, 1'b0);
      add(32'h0001_0000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      add(32'h0000_FFFC, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      add(32'h0001_1000, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b0);
      add(32'h0001_0FFC, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b1, 1'b0);
      add(32'h0001_0FFC, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      add(32'h0001_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, 1'b0);
      add(32'h0001_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      add(32'h0001_0030, 32'h600D_CAFE, 4'hF, 1'b0, 1'b1, 1'b1);
      add(32'h0001_0030, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) begin
         int unsigned r, w, op;
         logic [31:0] a;
         w  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 31) : 1020 + $urandom_range(0, 3);
         a  = BASE + 32'(4 * w);
         r  = $urandom_range(0, 99);
         if (r < 8) a = a | 32'($urandom_range(1, 3));
         else if (r < 14) begin
            case (r % 3)
               0: a = BASE - 32'd4;
               1: a = BASE + 32'(4 * WORDS);
               default: a = $urandom | 32'h8000_0000;
            endcase
         end
         op = $urandom_range(0, 9);
         add(a, $urandom, 4'($urandom_range(0, 15)), (op < 5) || (op == 9), (op >= 5),
             ($urandom_range(0, 19) == 0));
      end

      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check_eq($sformatf("dut%0d reset waitrequest", k), 32'(wait_o[k]), 32'd1);
         check_eq($sformatf("dut%0d reset readdata", k), rdata_o[k], 32'h0);
         check_eq($sformatf("dut%0d reset response", k), 32'(resp_o[k]), 32'h0);
      end
      rst_n = 1'b1;

      run_plan();

      plan.delete();
      add(32'h0001_0040, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      run_plan();

      // Reset lands while the WAIT_STATES 1 and 3 responders sit in WAIT on a write.
      @(negedge clk);
      for (int k = 1; k < NDUT; k++) begin
         addr_d[k] = 32'h0001_0040; wdata_d[k] = 32'h5555_5555; be_d[k] = 4'hF; wr_d[k] = 1'b1;
      end
      @(negedge clk);
      for (int k = 1; k < NDUT; k++) begin
         check_eq($sformatf("dut%0d waitrequest in WAIT", k), 32'(wait_o[k]), 32'd1);
      end
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         check_eq($sformatf("dut%0d mid-reset waitrequest", k), 32'(wait_o[k]), 32'd1);
         check_eq($sformatf("dut%0d mid-reset readdata", k), rdata_o[k], 32'h0);
         check_eq($sformatf("dut%0d mid-reset response", k), 32'(resp_o[k]), 32'h0);
         wr_d[k] = 1'b0; rd_d[k] = 1'b0;
         last_rd[k] = '0; last_resp[k] = 2'b00;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("dut%0d no pulse after reset", k), 32'(wait_o[k]), 32'd1);
         end
      end

      plan.delete();
      add(32'h0001_0040, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      add(32'h0001_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      run_plan();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
